alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 47 ++++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for the two-requester ALU arbiter.
// slave is the arbiter's view; master is the view of the surrounding environment.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic [DATA_W-1:0] req0_src1;
    logic [DATA_W-1:0] req0_src2;
    logic [DATA_W-1:0] req1_src1;
    logic [DATA_W-1:0] req1_src2;
    logic [OP_W-1:0]   req0_op;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_ready;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_src1, req0_src2, req1_src1, req1_src2,
        input  req0_op, req1_op,
        input  alu_result,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output alu_src1, alu_src2, alu_op,
        output rsp_valid, rsp_id, rsp_result
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_src1, req0_src2, req1_src1, req1_src2,
        output req0_op, req1_op,
        output alu_result,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_src1, alu_src2, alu_op,
        input  rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE accepts, EXEC lets the ALU settle on the
// registered operands, RESP holds the result until the consumer takes it.
// Round-robin between requesters using the index of the last completed response.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t            state_q;
    logic              last_id_q;
    logic [DATA_W-1:0] alu_src1_q;
    logic [DATA_W-1:0] alu_src2_q;
    logic [OP_W-1:0]   alu_op_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;

    logic              grant0_s;
    logic              grant1_s;
    logic              accept_s;
    logic [DATA_W-1:0] src1_sel_s;
    logic [DATA_W-1:0] src2_sel_s;
    logic [OP_W-1:0]   op_sel_s;

    // Winner selection: only in IDLE outside reset; on contention the requester not served last wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset && (state_q == S_IDLE)) begin
            grant0_s = bus.req0_valid && (!bus.req1_valid || last_id_q);
            grant1_s = bus.req1_valid && (!bus.req0_valid || !last_id_q);
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Operand mux feeding the capture registers from whichever requester is granted.
    always_comb begin
        src1_sel_s = bus.req0_src1;
        src2_sel_s = bus.req0_src2;
        op_sel_s   = bus.req0_op;
        if (grant1_s) begin
            src1_sel_s = bus.req1_src1;
            src2_sel_s = bus.req1_src2;
            op_sel_s   = bus.req1_op;
        end else begin
            src1_sel_s = bus.req0_src1;
            src2_sel_s = bus.req0_src2;
            op_sel_s   = bus.req0_op;
        end
    end

    assign accept_s       = grant0_s || grant1_s;
    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;

    // Arbitration FSM with registered ALU drive and response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_id_q    <= 1'b1;
            alu_src1_q   <= {DATA_W{1'b0}};
            alu_src2_q   <= {DATA_W{1'b0}};
            alu_op_q     <= {OP_W{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        alu_src1_q <= src1_sel_s;
                        alu_src2_q <= src2_sel_s;
                        alu_op_q   <= op_sel_s;
                        rsp_id_q   <= grant1_s;
                        state_q    <= S_EXEC;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    // ALU output has had a full cycle on the registered operands.
                    rsp_result_q <= bus.alu_result;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        last_id_q   <= rsp_id_q;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_src1   = alu_src1_q;
    assign bus.alu_src2   = alu_src2_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses into a scoreboard,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    typedef struct {
        logic        id;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared ALU model: ADD, SUB, MUL, and XOR for anything else.
    always_comb begin
        case (bus.alu_op)
            4'd0:    bus.alu_result = bus.alu_src1 + bus.alu_src2;
            4'd1:    bus.alu_result = bus.alu_src1 - bus.alu_src2;
            4'd2:    bus.alu_result = bus.alu_src1 * bus.alu_src2;
            default: bus.alu_result = bus.alu_src1 ^ bus.alu_src2;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [31:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        sb.push_back(e);
    endtask

    // Response monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d result=%0h expected none", bus.rsp_id, bus.rsp_result);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_result", bus.rsp_result, e.res);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int waitc;
        prev = 0;
        // Reset held two cycles with both requesters asking.
        reset = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;  bus.req0_src1 = 32'd20; bus.req0_src2 = 32'd10; bus.req0_op = 4'd1;
        bus.req1_valid = 1'b1;  bus.req1_src1 = 32'd5;  bus.req1_src2 = 32'd6;  bus.req1_op = 4'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("rst_rsp_result", bus.rsp_result, 32'd0);
            chk("rst_alu_src1", bus.alu_src1, 32'd0);
            chk("rst_alu_src2", bus.alu_src2, 32'd0);
            chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        end

        // Contention straight out of reset: req0 first, then req1.
        reset = 1'b1;
        #1;
        chk("cont_ready0", 32'(bus.req0_ready), 32'd1);
        chk("cont_ready1", 32'(bus.req1_ready), 32'd0);
        push(1'b0, 32'd10);
        push(1'b1, 32'd30);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("cont_exec_ready1", 32'(bus.req1_ready), 32'd0);
        chk("cont_alu_src1", bus.alu_src1, 32'd20);
        chk("cont_alu_op", 32'(bus.alu_op), 32'd1);
        tick();
        chk("cont_resp_ready1", 32'(bus.req1_ready), 32'd0);
        chk("cont_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        tick();
        chk("cont_ready1_after", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        tick();

        // Fairness: both valid continuously, four grants alternate 0,1,0,1 every 3 cycles.
        bus.req0_src1 = 32'd1; bus.req0_src2 = 32'd2; bus.req0_op = 4'd0;
        bus.req1_src1 = 32'd7; bus.req1_src2 = 32'd3; bus.req1_op = 4'd1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        push(1'b0, 32'd3); push(1'b1, 32'd4); push(1'b0, 32'd3); push(1'b1, 32'd4);
        #1;
        for (int k = 0; k < 4; k++) begin
            waitc = 0;
            while (!(bus.req0_ready || bus.req1_ready) && waitc < 10) begin
                tick();
                waitc++;
            end
            chk("fair_grant_seen", 32'(bus.req0_ready || bus.req1_ready), 32'd1);
            chk("fair_id", 32'(bus.req1_ready), 32'(k % 2));
            if (k > 0) chk("fair_interval", 32'(cyc - prev), 32'd3);
            prev = cyc;
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (3) tick();

        // Single op: 10+5 from req0, latency and one-cycle response pulse.
        bus.req0_src1 = 32'd10; bus.req0_src2 = 32'd5; bus.req0_op = 4'd0;
        bus.req0_valid = 1'b1;
        #1;
        chk("single_ready0", 32'(bus.req0_ready), 32'd1);
        push(1'b0, 32'd15);
        tick();
        bus.req0_valid = 1'b0;
        chk("single_alu_src1", bus.alu_src1, 32'd10);
        chk("single_alu_src2", bus.alu_src2, 32'd5);
        chk("single_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_rsp_result", bus.rsp_result, 32'd15);
        tick();
        chk("single_pulse_end", 32'(bus.rsp_valid), 32'd0);

        // Backpressure: response held four cycles while both requesters wait.
        bus.req0_valid = 1'b1;
        bus.rsp_ready  = 1'b0;
        push(1'b0, 32'd15);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_result", bus.rsp_result, 32'd15);
            chk("bp_alu_src1", bus.alu_src1, 32'd10);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        tick();
        chk("bp_release", 32'(bus.rsp_valid), 32'd0);

        // Undefined opcode passes through untouched.
        bus.req1_src1 = 32'd3; bus.req1_src2 = 32'd4; bus.req1_op = 4'b1011;
        bus.req1_valid = 1'b1;
        #1;
        chk("undef_ready1", 32'(bus.req1_ready), 32'd1);
        push(1'b1, 32'd7);
        tick();
        bus.req1_valid = 1'b0;
        chk("undef_alu_op", 32'(bus.alu_op), 32'd11);
        tick();
        tick();

        // Reset during EXEC discards the op; a following req1 op completes normally.
        bus.req0_src1 = 32'd10; bus.req0_src2 = 32'd5; bus.req0_op = 4'd0;
        bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        bus.req1_valid = 1'b1;
        #1;
        chk("midrst_ready1", 32'(bus.req1_ready), 32'd0);
        bus.req1_valid = 1'b0;
        tick();
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b1;
        tick();
        chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.req1_src1 = 32'd10; bus.req1_src2 = 32'd5; bus.req1_op = 4'd0;
        bus.req1_valid = 1'b1;
        #1;
        chk("post_rst_ready1", 32'(bus.req1_ready), 32'd1);
        push(1'b1, 32'd15);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("post_rst_rsp_id", 32'(bus.rsp_id), 32'd1);
        chk("post_rst_rsp_result", bus.rsp_result, 32'd15);
        tick();
        tick();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
